// File: rtl/rsc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rsc_pkg
//  Description : Shared widths, writeback state encoding and flag bit indices
//                for the ALU writeback stage.
//  Revision    : 1.0  initial release
// ============================================================================
package rsc_pkg;

  localparam int DATA_W = 16;
  localparam int REG_AW = 3;

  // Writeback sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2
  } wb_state_t;

  // Bit positions inside the {za, zb, eq, gt, lt} flag vector
  localparam int FLG_ZA = 4;
  localparam int FLG_ZB = 3;
  localparam int FLG_EQ = 2;
  localparam int FLG_GT = 1;
  localparam int FLG_LT = 0;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Enabled up-counter that sticks at all-ones instead of
//                wrapping. Asynchronous active-low reset.
//  Revision    : 1.0  initial release
// ============================================================================
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  // Count enabled events, holding at the maximum value once reached
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : alu_writeback
//  Description : Writeback stage behind the 16-bit ALU. Captures a 32-bit
//                result, sequences one (narrow) or two (wide) register-file
//                writes through a single write port, keeps the architectural
//                flag register and counts retired instructions.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_writeback #(
  parameter int DATA_W = rsc_pkg::DATA_W,
  parameter int REG_AW = rsc_pkg::REG_AW,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*DATA_W-1:0] in_result,
  input  logic [REG_AW-1:0]   in_rd,
  input  logic                in_wide,
  input  logic [4:0]          in_flags,
  input  logic                in_flag_en,
  output logic                rf_we,
  output logic [REG_AW-1:0]   rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic [4:0]          flags_q,
  output logic [CNT_W-1:0]    retired,
  output logic                busy
);

  import rsc_pkg::*;

  wb_state_t            state_q;
  wb_state_t            state_d;
  logic [2*DATA_W-1:0]  res_q;
  logic [REG_AW-1:0]    rd_q;
  logic                 wide_q;
  logic                 xfer;
  logic                 retire_en;

  // Only the low half of a wide op blocks the next transfer
  assign in_ready  = !((state_q == WR_LO) && wide_q);
  assign xfer      = in_valid && in_ready;
  // An instruction retires when it leaves its last write cycle
  assign retire_en = ((state_q == WR_LO) && !wide_q) || (state_q == WR_HI);
  assign busy      = (state_q != IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the accepted result; flags commit at transfer time so that
  // compare-only ops stay ordered with later writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q   <= '0;
      rd_q    <= '0;
      wide_q  <= 1'b0;
      flags_q <= '0;
    end else if (xfer) begin
      res_q  <= in_result;
      rd_q   <= in_rd;
      wide_q <= in_wide;
      if (in_flag_en) begin
        flags_q <= in_flags;
      end
    end
  end

  // Next-state and Moore write-port decode
  always_comb begin
    state_d  = IDLE;
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    case (state_q)
      IDLE: begin
        state_d = xfer ? WR_LO : IDLE;
      end
      WR_LO: begin
        rf_we    = 1'b1;
        rf_waddr = rd_q;
        rf_wdata = res_q[DATA_W-1:0];
        if (wide_q) begin
          state_d = WR_HI;
        end else begin
          state_d = xfer ? WR_LO : IDLE;
        end
      end
      WR_HI: begin
        rf_we    = 1'b1;
        rf_waddr = rd_q + 1'b1;  // wraps modulo register count
        rf_wdata = res_q[2*DATA_W-1:DATA_W];
        state_d  = xfer ? WR_LO : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_retired (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (retire_en),
    .count (retired)
  );

endmodule
`default_nettype wire

// File: tb/tb_alu_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_writeback
//  Description : Directed self-checking bench for alu_writeback. A second,
//                narrow-counter instance exercises retired-count saturation.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_writeback;

  logic        clk;
  logic        rst_n;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [2:0]  in_rd;
  logic        in_wide;
  logic [4:0]  in_flags;
  logic        in_flag_en;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic [4:0]  flags_q;
  logic [15:0] retired;
  logic        busy;

  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_result;
  logic [2:0]  s_rd;
  logic        s_rf_we;
  logic [2:0]  s_waddr;
  logic [15:0] s_wdata;
  logic [4:0]  s_flags_q;
  logic [1:0]  s_retired;
  logic        s_busy;

  int vectors;
  int miscompares;

  alu_writeback #(.DATA_W(16), .REG_AW(3), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_rd      (in_rd),
    .in_wide    (in_wide),
    .in_flags   (in_flags),
    .in_flag_en (in_flag_en),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .flags_q    (flags_q),
    .retired    (retired),
    .busy       (busy)
  );

  // Two-bit counter instance so saturation is reachable in a few cycles
  alu_writeback #(.DATA_W(16), .REG_AW(3), .CNT_W(2)) dut_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (s_valid),
    .in_ready   (s_ready),
    .in_result  (s_result),
    .in_rd      (s_rd),
    .in_wide    (1'b0),
    .in_flags   (5'b00000),
    .in_flag_en (1'b0),
    .rf_we      (s_rf_we),
    .rf_waddr   (s_waddr),
    .rf_wdata   (s_wdata),
    .flags_q    (s_flags_q),
    .retired    (s_retired),
    .busy       (s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_result   = '0;
    in_rd       = '0;
    in_wide     = 1'b0;
    in_flags    = '0;
    in_flag_en  = 1'b0;
    s_valid     = 1'b0;
    s_result    = '0;
    s_rd        = '0;

    step();
    step();
    chk("rst_we",      {31'd0, rf_we},    32'd0);
    chk("rst_busy",    {31'd0, busy},     32'd0);
    chk("rst_retired", {16'd0, retired},  32'd0);
    chk("rst_flags",   {27'd0, flags_q},  32'd0);
    rst_n = 1'b1;
    chk("rst_ready",   {31'd0, in_ready}, 32'd1);

    // Reset in the middle of a wide op
    in_valid = 1'b1; in_result = 32'h1234_5678; in_rd = 3'd2; in_wide = 1'b1;
    in_flag_en = 1'b1; in_flags = 5'b10101;
    step();
    in_valid = 1'b0;
    chk("mid_lo_we",    {31'd0, rf_we},    32'd1);
    chk("mid_lo_addr",  {29'd0, rf_waddr}, 32'd2);
    chk("mid_lo_data",  {16'd0, rf_wdata}, 32'h5678);
    chk("mid_lo_ready", {31'd0, in_ready}, 32'd0);
    chk("mid_flags",    {27'd0, flags_q},  32'h15);
    #2 rst_n = 1'b0;
    #1;
    chk("async_we",      {31'd0, rf_we},   32'd0);
    chk("async_flags",   {27'd0, flags_q}, 32'd0);
    chk("async_retired", {16'd0, retired}, 32'd0);
    step();
    chk("no_hi_we",      {31'd0, rf_we},   32'd0);
    rst_n = 1'b1;
    in_flag_en = 1'b0;
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);

    // Narrow op with flag update
    in_valid = 1'b1; in_result = 32'h0000_ABCD; in_rd = 3'd5; in_wide = 1'b0;
    in_flag_en = 1'b1; in_flags = 5'b00100;
    step();
    in_valid = 1'b0; in_flag_en = 1'b0;
    chk("nar_we",    {31'd0, rf_we},    32'd1);
    chk("nar_addr",  {29'd0, rf_waddr}, 32'd5);
    chk("nar_data",  {16'd0, rf_wdata}, 32'hABCD);
    chk("nar_flags", {27'd0, flags_q},  32'h04);
    chk("nar_ret0",  {16'd0, retired},  32'd0);
    step();
    chk("nar_idle",  {31'd0, busy},     32'd0);
    chk("nar_we0",   {31'd0, rf_we},    32'd0);
    chk("nar_ret1",  {16'd0, retired},  32'd1);

    // Wide op with rd+1 wrapping 7 -> 0
    in_valid = 1'b1; in_result = 32'hDEAD_BEEF; in_rd = 3'd7; in_wide = 1'b1;
    step();
    in_valid = 1'b0;
    chk("wid_lo_addr",  {29'd0, rf_waddr}, 32'd7);
    chk("wid_lo_data",  {16'd0, rf_wdata}, 32'hBEEF);
    chk("wid_lo_ready", {31'd0, in_ready}, 32'd0);
    chk("wid_lo_ret",   {16'd0, retired},  32'd1);
    step();
    chk("wid_hi_we",    {31'd0, rf_we},    32'd1);
    chk("wid_hi_addr",  {29'd0, rf_waddr}, 32'd0);
    chk("wid_hi_data",  {16'd0, rf_wdata}, 32'hDEAD);
    chk("wid_hi_ret",   {16'd0, retired},  32'd1);
    step();
    chk("wid_done_we",  {31'd0, rf_we},    32'd0);
    chk("wid_done_ret", {16'd0, retired},  32'd2);

    // Four back-to-back narrow ops
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_wide = 1'b0;
      in_rd = 3'(i);
      in_result = 32'(8'h11 * (i + 1));
      chk("b2b_ready", {31'd0, in_ready}, 32'd1);
      step();
      chk("b2b_we",   {31'd0, rf_we},    32'd1);
      chk("b2b_addr", {29'd0, rf_waddr}, 32'(i));
      chk("b2b_data", {16'd0, rf_wdata}, 32'(8'h11 * (i + 1)));
    end
    in_valid = 1'b0;
    step();
    chk("b2b_ret", {16'd0, retired}, 32'd6);

    // Wide followed by a narrow that must wait for the high-half cycle
    in_valid = 1'b1; in_result = 32'hCAFE_0001; in_rd = 3'd1; in_wide = 1'b1;
    step();
    chk("wn_lo_data",  {16'd0, rf_wdata}, 32'h0001);
    chk("wn_lo_ready", {31'd0, in_ready}, 32'd0);
    in_result = 32'h0000_0077; in_rd = 3'd4; in_wide = 1'b0;
    step();
    chk("wn_hi_addr",  {29'd0, rf_waddr}, 32'd2);
    chk("wn_hi_data",  {16'd0, rf_wdata}, 32'hCAFE);
    chk("wn_hi_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("wn_nar_we",   {31'd0, rf_we},    32'd1);
    chk("wn_nar_addr", {29'd0, rf_waddr}, 32'd4);
    chk("wn_nar_data", {16'd0, rf_wdata}, 32'h0077);
    step();
    chk("wn_ret", {16'd0, retired}, 32'd8);

    // Flags held when flag_en is low, then a compare-only style update
    in_valid = 1'b1; in_result = 32'h0; in_rd = 3'd3; in_wide = 1'b0;
    in_flag_en = 1'b0; in_flags = 5'b11111;
    step();
    chk("hold_flags", {27'd0, flags_q}, 32'h04);
    in_flag_en = 1'b1; in_flags = 5'b01010;
    step();
    in_valid = 1'b0; in_flag_en = 1'b0;
    chk("upd_flags", {27'd0, flags_q}, 32'h0A);
    step();
    chk("flag_ret", {16'd0, retired}, 32'd10);

    // Saturating retired counter on the 2-bit instance
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_rd = 3'(i); s_result = 32'(i);
      step();
    end
    chk("sat_mid", {30'd0, s_retired}, 32'd2);
    for (int i = 0; i < 4; i++) begin
      step();
    end
    s_valid = 1'b0;
    step();
    chk("sat_hold", {30'd0, s_retired}, 32'd3);
    chk("sat_idle", {31'd0, s_busy},    32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
